ram_ctrl: RTL
=============

Name: ram_ctrl

Overview:
- Initiator-side controller for the 16x4 single-port scratch RAM; it drives the RAM's we, oe, mem_add and mem_in and samples its mem_out.
- Turns a host valid/ready request interface into correctly timed RAM write and read cycles, and returns read data on a one-cycle response strobe.
- Also provides a hardware fill command that writes one value to every RAM location.
- Sits between the datapath/sequencer and the RAM macro; it is the only agent that drives the RAM control pins.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- DATA_W, 4, RAM word width.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse: request completed.
- rsp_rdata  out  DATA_W  read data when rsp_valid follows a read; 0 after a write.
- fill_start  in  1  start a fill of every location with fill_val.
- fill_val  in  DATA_W  fill data, sampled at acceptance.
- fill_done  out  1  one-cycle pulse when the fill completes.
- busy  out  1  high whenever state != IDLE.
- we  out  1  RAM write enable, registered.
- oe  out  1  RAM output enable, registered.
- mem_add  out  ADDR_W  RAM address, registered.
- mem_in  out  DATA_W  RAM write data, registered.
- mem_out  in  DATA_W  RAM read data; combinational from RAM; Z when we = oe = 0.

Behaviour:
- Reset (sync, rst = 1 at posedge):
  - State goes to IDLE.
  - we, oe, rsp_valid, fill_done and busy = 0.
  - mem_add, mem_in and rsp_rdata = 0; fill counter = 0.
  - Overrides any operation in progress. An abandoned fill leaves the RAM partially written; no fill_done or rsp_valid is issued.
- States: IDLE, WR, RD, FILL.
- req_ready = (state == IDLE), combinational from state.
- IDLE:
  - Accept fill_start first. When fill_start = 1, go to FILL, latch fill_val, counter = 0. A simultaneous req_valid is not accepted; req_ready still reads 1 that cycle, but the host must hold the request.
  - Else, on req_valid = 1 at posedge E0, latch addr/wdata/write and go to WR or RD.
- WR (cycle after E0):
  - we = 1, oe = 0, mem_add = addr, mem_in = wdata. The RAM writes at E1.
  - At E1: return to IDLE, we = 0; rsp_valid = 1 and rsp_rdata = 0 for the cycle after E1.
- RD (cycle after E0):
  - oe = 1, we = 0, mem_add = addr.
  - At E1: capture mem_out into rsp_rdata; return to IDLE; rsp_valid = 1 for the cycle after E1.
- Latency: request to rsp_valid = 2 cycles. A new request may be accepted in the same cycle rsp_valid is high, so peak throughput is 1 request per 2 cycles.
- mem_out is sampled only at the end of an RD cycle, never while we = oe = 0 (bus is Z then).
- FILL:
  - For 2**ADDR_W consecutive cycles: we = 1, mem_add = counter, mem_in = latched fill_val. Counter increments each cycle, 0..15.
  - After the write to the last address (15 → wrap), return to IDLE; fill_done = 1 the following cycle.
  - Total: acceptance to fill_done = 17 cycles at default width.
  - fill_start and req_valid are ignored while in FILL.
- Output hold rules:
  - rsp_rdata holds its value until the next response.
  - mem_add holds its last value in IDLE.
  - we and oe are both 0 in IDLE and never both 1.
- Input stability: req_* and fill_val need be stable only on the accepting edge.

Test Plan:
- Reset: assert rst 2 cycles mid-FILL (counter = 7) → next cycle we = oe = busy = 0, req_ready = 1, no fill_done ever pulses.
- Write then read: write addr 0x5 data 0xA, then read addr 0x5 → we = 1 with mem_add = 5 and mem_in = A for exactly 1 cycle; read rsp_valid 2 cycles after acceptance with rsp_rdata = 0xA.
- Back-to-back: hold req_valid with reads of addr 3, 4, 5 (preloaded 0x3, 0x4, 0x5) → acceptances every 2 cycles; rsp_rdata = 3, 4, 5 on consecutive rsp_valid pulses; req_ready low exactly during RD cycles.
- Fill: fill_start with fill_val = 0xC → 16 cycles of we = 1 with mem_add 0..15; fill_done 17 cycles after acceptance; reads of addr 0 and 15 return 0xC.
- Collision: fill_start and req_valid (write addr 2, data 0x1) in the same IDLE cycle → FILL runs first; the held write is accepted after fill_done, and addr 2 then reads 0x1 while the others read the fill value.
- Bus discipline: assertion over all tests: never we & oe; rsp_rdata never X/Z at rsp_valid after a read.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: sequences host read/write requests and whole-RAM fills onto the we/oe/mem_add/mem_in pins of a single-port RAM
module ram_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_val,
  output logic              fill_done,
  output logic              busy,
  output logic              we,
  output logic              oe,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);
  typedef enum logic [1:0] {IDLE, WR, RD, FILL} state_t;
  state_t state;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      we <= 1'b0;
      oe <= 1'b0;
      rsp_valid <= 1'b0;
      fill_done <= 1'b0;
      mem_add <= '0;
      mem_in <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      fill_done <= 1'b0;
      case (state)
        IDLE:
          if (fill_start) begin
            state <= FILL;
            we <= 1'b1;
            mem_add <= '0;
            mem_in <= fill_val;
          end else if (req_valid) begin
            state <= req_write ? WR : RD;
            we <= req_write;
            oe <= !req_write;
            mem_add <= req_addr;
            mem_in <= req_write ? req_wdata : mem_in;
          end
        WR: begin
          state <= IDLE;
          we <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
        end
        RD: begin
          state <= IDLE;
          oe <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_out;
        end
        FILL:
          if (mem_add == '1) begin
            state <= IDLE;
            we <= 1'b0;
            fill_done <= 1'b1;
          end else
            mem_add <= mem_add + ADDR_W'(1);
      endcase
    end
endmodule
